// File: rtl/uart_mem_loader.sv
// Length-framed UART-to-RAM loader: sends a prompt, receives LEN + payload + checksum,
// writes the payload to RAM from address 0 and replies with ACK or NAK.
module uart_mem_loader #(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] PROMPT_BYTE = 8'd100,
  parameter logic [7:0] ACK_BYTE    = 8'hAA,
  parameter logic [7:0] NAK_BYTE    = 8'h55,
  parameter int         TIMEOUT_CYC = 50000000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              RX_DONE,
  input  logic [7:0]        RX_DATA,
  input  logic              TX_READY,
  output logic              TX_SEND,
  output logic [7:0]        TX_DATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_DIN,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        ERR_CODE,
  output logic [ADDR_W:0]   BYTE_COUNT
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  // Length comparisons need room for both a 16-bit length and the 2**ADDR_W capacity
  localparam int CMP_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
  localparam logic [CMP_W-1:0] CAPACITY = CMP_W'(1) << ADDR_W;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_LEN  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_P_SEND, S_P_GAP, S_P_WAIT, S_LEN_HI, S_LEN_LO, S_DATA,
    S_WRITE, S_CSUM, S_R_SEND, S_R_GAP, S_R_WAIT, S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_err;
  logic [1:0]          w_err_next;
  logic [15:0]         r_len;
  logic [ADDR_W-1:0]   r_index;
  logic [ADDR_W:0]     r_byte_count;
  logic [7:0]          r_sum;
  logic [7:0]          r_tx_data;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_din;
  logic [TMO_W-1:0]    r_tmo;

  logic [CMP_W-1:0]    w_len_new;
  logic                w_last;
  logic                w_tmo;
  logic                w_counting;
  logic                w_enter_len_hi;
  logic                w_enter_r_send;

  assign w_len_new      = CMP_W'({r_len[15:8], RX_DATA});
  assign w_last         = (CMP_W'(r_index) == (CMP_W'(r_len) - CMP_W'(1)));
  assign w_counting     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_tmo          = w_counting && (r_tmo == TMO_LAST);
  assign w_enter_len_hi = (w_state_next == S_LEN_HI) && (r_state != S_LEN_HI);
  assign w_enter_r_send = (w_state_next == S_R_SEND) && (r_state != S_R_SEND);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
    end
  end

  // RX_DONE is tested before the timeout everywhere, so a received byte beats a coincident expiry
  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next = S_P_SEND;
          w_err_next   = ERR_OK;
        end
      end
      S_P_SEND: if (TX_READY) w_state_next = S_P_GAP;
      S_P_GAP:  w_state_next = S_P_WAIT;
      S_P_WAIT: if (TX_READY) w_state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (RX_DONE) begin
          w_state_next = S_LEN_LO;
        end else if (w_tmo) begin
          w_state_next = S_R_SEND;
          w_err_next   = ERR_TMO;
        end
      end
      S_LEN_LO: begin
        if (RX_DONE) begin
          if (w_len_new > CAPACITY) begin
            w_state_next = S_R_SEND;
            w_err_next   = ERR_LEN;
          end else if (w_len_new == '0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end else if (w_tmo) begin
          w_state_next = S_R_SEND;
          w_err_next   = ERR_TMO;
        end
      end
      S_DATA: begin
        if (RX_DONE) begin
          w_state_next = S_WRITE;
        end else if (w_tmo) begin
          w_state_next = S_R_SEND;
          w_err_next   = ERR_TMO;
        end
      end
      S_WRITE: w_state_next = w_last ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (RX_DONE) begin
          w_state_next = S_R_SEND;
          if (RX_DATA != r_sum) w_err_next = ERR_CSUM;
        end else if (w_tmo) begin
          w_state_next = S_R_SEND;
          w_err_next   = ERR_TMO;
        end
      end
      S_R_SEND: if (TX_READY) w_state_next = S_R_GAP;
      S_R_GAP:  w_state_next = S_R_WAIT;
      S_R_WAIT: if (TX_READY) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    TX_SEND = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    MEM_EN  = 1'b0;
    if (r_state != S_IDLE) BUSY = 1'b1;
    if ((r_state != S_IDLE) && (r_state != S_FINISH)) MEM_EN = 1'b1;
    if (r_state == S_FINISH) DONE = 1'b1;
    if (((r_state == S_P_SEND) || (r_state == S_R_SEND)) && TX_READY) TX_SEND = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tmo <= '0;
    end else if (RX_DONE || w_enter_len_hi) begin
      r_tmo <= '0;
    end else if (w_counting) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // Frame datapath: length capture, payload write strobe, running checksum, reply byte
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_len        <= '0;
      r_index      <= '0;
      r_byte_count <= '0;
      r_sum        <= '0;
      r_tx_data    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if ((r_state == S_IDLE) && START) begin
        r_index      <= '0;
        r_byte_count <= '0;
        r_sum        <= '0;
        r_tx_data    <= PROMPT_BYTE;
      end
      if ((r_state == S_LEN_HI) && RX_DONE) r_len[15:8] <= RX_DATA;
      if ((r_state == S_LEN_LO) && RX_DONE) r_len[7:0]  <= RX_DATA;
      if ((r_state == S_DATA) && RX_DONE) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_index;
        r_mem_din  <= RX_DATA;
        r_sum      <= r_sum + RX_DATA;
      end
      if (r_state == S_WRITE) begin
        r_index      <= r_index + ADDR_W'(1);
        r_byte_count <= r_byte_count + (ADDR_W + 1)'(1);
      end
      if (w_enter_r_send) r_tx_data <= (w_err_next == ERR_OK) ? ACK_BYTE : NAK_BYTE;
    end
  end

  assign TX_DATA    = r_tx_data;
  assign MEM_WE     = r_mem_we;
  assign MEM_ADDR   = r_mem_addr;
  assign MEM_DIN    = r_mem_din;
  assign ERR_CODE   = r_err;
  assign BYTE_COUNT = r_byte_count;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: expected writes and TX bytes are queued as
// stimulus is driven and compared when the DUT strobes MEM_WE / TX_SEND.
module tb_uart_mem_loader;

  localparam int ADDR_W = 4;
  localparam int TMO    = 1000;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0;
  logic              RX_DONE = 1'b0;
  logic [7:0]        RX_DATA = 8'h00;
  logic              TX_READY = 1'b1;
  logic              TX_SEND;
  logic [7:0]        TX_DATA;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_DIN;
  logic              BUSY;
  logic              DONE;
  logic [1:0]        ERR_CODE;
  logic [ADDR_W:0]   BYTE_COUNT;

  uart_mem_loader #(.ADDR_W(ADDR_W), .PROMPT_BYTE(8'd100), .ACK_BYTE(8'hAA),
                    .NAK_BYTE(8'h55), .TIMEOUT_CYC(TMO)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .RX_DONE(RX_DONE), .RX_DATA(RX_DATA),
    .TX_READY(TX_READY), .TX_SEND(TX_SEND), .TX_DATA(TX_DATA), .MEM_EN(MEM_EN),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .BUSY(BUSY), .DONE(DONE),
    .ERR_CODE(ERR_CODE), .BYTE_COUNT(BYTE_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;
  int wa_q[$];
  int wd_q[$];
  int tx_q[$];
  logic [7:0] pay [0:31];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural uart_tx: busy for a few cycles after each send strobe
  initial begin
    forever begin
      @(negedge CLK);
      if (TX_SEND) begin
        @(posedge CLK);
        #1 TX_READY = 1'b0;
        repeat (4) @(posedge CLK);
        #1 TX_READY = 1'b1;
      end
    end
  end

  // Output monitor / scoreboard compare
  initial begin
    forever begin
      @(negedge CLK);
      if (MEM_WE) begin
        if (wa_q.size() == 0) check_eq("wr_unexpected", 1, 0);
        else begin
          check_eq("wr_addr", MEM_ADDR, wa_q.pop_front());
          check_eq("wr_data", MEM_DIN, wd_q.pop_front());
        end
      end
      if (TX_SEND) begin
        tx_cnt++;
        if (tx_q.size() == 0) check_eq("tx_unexpected", 1, 0);
        else check_eq("tx_byte", TX_DATA, tx_q.pop_front());
      end
      if (DONE) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1 RX_DONE = 1'b1; RX_DATA = b;
    @(posedge CLK); #1 RX_DONE = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic wait_prompt();
    int start_cnt = tx_cnt;
    int k = 0;
    while (tx_cnt == start_cnt && k < 100) begin @(posedge CLK); k++; end
    check_eq("prompt_seen", tx_cnt > start_cnt, 1);
    repeat (10) @(posedge CLK);
  endtask

  task automatic run_frame(input logic [15:0] len, input int n_pay, input bit send_csum,
                           input logic [7:0] csum, input logic [1:0] exp_err,
                           input int exp_cnt, input bit restart_probe);
    int start_done = done_cnt;
    int k = 0;
    tx_q.push_back(100);
    tx_q.push_back(exp_err == 2'd0 ? 8'hAA : 8'h55);
    pulse_start();
    wait_prompt();
    #1 check_eq("busy_len_hi", BUSY, 1);
    if (restart_probe) pulse_start();
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < n_pay; i++) begin
      wa_q.push_back(i);
      wd_q.push_back(pay[i]);
      send_byte(pay[i]);
    end
    if (send_csum) send_byte(csum);
    while (done_cnt == start_done && k < 3 * TMO) begin @(posedge CLK); k++; end
    check_eq("done_seen", done_cnt > start_done, 1);
    #1;
    check_eq("err_code", ERR_CODE, exp_err);
    check_eq("byte_count", BYTE_COUNT, exp_cnt);
    check_eq("busy_after", BUSY, 0);
    check_eq("mem_en_after", MEM_EN, 0);
    check_eq("wr_q_left", wa_q.size(), 0);
    check_eq("tx_q_left", tx_q.size(), 0);
    wa_q.delete(); wd_q.delete(); tx_q.delete();
    repeat (5) @(posedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_send"}, TX_SEND, 0);
    check_eq({tag, "_tx_data"}, TX_DATA, 0);
    check_eq({tag, "_mem_en"}, MEM_EN, 0);
    check_eq({tag, "_mem_we"}, MEM_WE, 0);
    check_eq({tag, "_mem_addr"}, MEM_ADDR, 0);
    check_eq({tag, "_mem_din"}, MEM_DIN, 0);
    check_eq({tag, "_busy"}, BUSY, 0);
    check_eq({tag, "_done"}, DONE, 0);
    check_eq({tag, "_err"}, ERR_CODE, 0);
    check_eq({tag, "_count"}, BYTE_COUNT, 0);
  endtask

  initial begin
    logic [7:0] sum;
    repeat (3) @(posedge CLK);
    #1 check_all_zero("reset");
    @(posedge CLK); #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);

    // good 3-byte frame, with a START probe while busy
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_frame(16'h0003, 3, 1'b1, 8'h66, 2'd0, 3, 1'b1);
    // bad checksum
    run_frame(16'h0003, 3, 1'b1, 8'h67, 2'd1, 3, 1'b0);
    // timeout after one of two bytes
    pay[0] = 8'h5A;
    run_frame(16'h0002, 1, 1'b0, 8'h00, 2'd2, 1, 1'b0);
    // length beyond capacity
    run_frame(16'h0011, 0, 1'b0, 8'h00, 2'd3, 0, 1'b0);
    // full capacity
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      sum = sum + pay[i];
    end
    run_frame(16'h0010, 16, 1'b1, sum, 2'd0, 16, 1'b0);
    // zero-length frame
    run_frame(16'h0000, 0, 1'b1, 8'h00, 2'd0, 0, 1'b0);

    // reset abort while a write strobe is active
    tx_q.push_back(100);
    pulse_start();
    wait_prompt();
    send_byte(8'h00);
    send_byte(8'h04);
    pay[0] = 8'hC3;
    wa_q.push_back(0); wd_q.push_back(pay[0]);
    send_byte(pay[0]);
    @(posedge CLK); #1 RX_DONE = 1'b1; RX_DATA = 8'h7E;
    @(posedge CLK); #1 RX_DONE = 1'b0;
    check_eq("we_before_rst", MEM_WE, 1);
    #1 RESET_N = 1'b0;
    #1 check_all_zero("abort");
    @(posedge CLK); #1 RESET_N = 1'b1;
    repeat (30) @(posedge CLK);
    #1 check_eq("idle_after_abort", BUSY, 0);
    check_eq("abort_wr_q_left", wa_q.size(), 0);
    check_eq("abort_tx_q_left", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
